spectrum_bar_renderer: RTL and testbench

Parametrised spectrum-bar pixel renderer. It sits between the FFT core and the VGA timing generator. FFT frames are captured on `i_fft_done` and converted to log-scaled bar heights once per video frame, during vertical blanking. An optional peak-hold marker decays over frames. Pixel colour is produced through a 2-stage pipeline from the current VGA coordinate.

---
 rtl/spectrum_bar_renderer_pkg.sv | 20 ++
 rtl/spectrum_bar_renderer_log2.sv | 19 +
 rtl/spectrum_bar_renderer.sv | 213 +++++++++++++++++++++
 tb/tb_spectrum_bar_renderer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_bar_renderer_pkg.sv
// Shared types and colour constants for the spectrum bar renderer.
// Pixel colour is a packed R/G/B triple; the update FSM has two states.
package renderer_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t C_GREEN = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t C_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

endpackage

// File: rtl/spectrum_bar_renderer_log2.sv
// Floor-log2 priority encoder, combinational (0 cycles); log2(0) reads as 0.
// No handshake: output follows input within the same cycle.
module log2 #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]  val_i,
  output logic [OUT_W-1:0] lg_o
);

  always_comb begin
    lg_o = '0;
    // Highest set bit wins because later iterations overwrite earlier ones.
    for (int i = 0; i < IN_W; i++) begin
      if (val_i[i]) lg_o = OUT_W'(i);
    end
  end

endmodule

// File: rtl/spectrum_bar_renderer.sv
// Log-scaled spectrum bar renderer: FFT capture, per-frame height update, 2-cycle pixel path.
// No backpressure; SPECTRUM_PEAK_HOLD_EN adds per-bar peak-hold marker storage and drawing.
module spectrum_bar_renderer
  import renderer_pkg::*;
#(
  parameter int N_BINS           = 32,
  parameter int DATA_W           = 16,
  parameter int BAR_W            = 16,
  parameter int SCREEN_H         = 480,
  parameter int BAR_STEP         = 16,
  parameter int PEAK_HOLD_FRAMES = 30,
  parameter int DECAY_STEP       = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_BINS-1:0][DATA_W-1:0]  i_fft_data,
  input  logic                           i_fft_done,
  input  logic                           i_frame_start,
  input  logic [10:0]                    i_VGA_X,
  input  logic [10:0]                    i_VGA_Y,
  output logic [7:0]                     o_VGA_R,
  output logic [7:0]                     o_VGA_G,
  output logic [7:0]                     o_VGA_B,
  output logic                           o_busy
);

  localparam int BIN_W   = (N_BINS > 1) ? $clog2(N_BINS) : 1;
  localparam int H_W     = $clog2(SCREEN_H + 1);
  localparam int MAG_W   = DATA_W - 1;
  localparam int LG_W    = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam int BARS_PX = N_BINS * BAR_W;

  logic [N_BINS-1:0][DATA_W-1:0] shadow_q;
  logic [N_BINS-1:0][DATA_W-1:0] work_q;
  logic [N_BINS-1:0][H_W-1:0]    height_q;
  logic                          pending_q;
  state_t                        state_q;
  logic [BIN_W-1:0]              bin_idx_q;
  logic                          busy_q;

  logic [DATA_W-1:0] sample;
  logic [MAG_W-1:0]  abs_val;
  logic [LG_W-1:0]   lg;
  logic [31:0]       h_raw;
  logic [H_W-1:0]    height_new;

  always_comb begin
    sample = work_q[bin_idx_q];
    if (!sample[DATA_W-1]) begin
      abs_val = sample[MAG_W-1:0];
    end else if (sample[MAG_W-1:0] == '0) begin
      abs_val = '1;
    end else begin
      abs_val = MAG_W'(~sample + 1'b1);
    end
  end

  log2 #(
    .IN_W  (MAG_W),
    .OUT_W (LG_W)
  ) u_log2 (
    .val_i (abs_val),
    .lg_o  (lg)
  );

  always_comb begin
    h_raw      = (32'(lg) + 32'd1) * 32'(BAR_STEP);
    height_new = (h_raw >= 32'(SCREEN_H)) ? H_W'(SCREEN_H) : h_raw[H_W-1:0];
  end

  // Capture, snapshot and update FSM; capture keeps running while UPDATE walks the bins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      bin_idx_q <= '0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      work_q    <= '0;
      height_q  <= '0;
    end else begin
      if (i_fft_done) shadow_q <= i_fft_data;

      if (i_fft_done) begin
        pending_q <= 1'b1;
      end else if (state_q == IDLE && i_frame_start) begin
        pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (i_frame_start) begin
            if (pending_q) work_q <= shadow_q;
            state_q   <= UPDATE;
            bin_idx_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        UPDATE: begin
          height_q[bin_idx_q] <= height_new;
          if (bin_idx_q == BIN_W'(N_BINS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            bin_idx_q <= bin_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(PEAK_HOLD_FRAMES + 1);

  logic [N_BINS-1:0][H_W-1:0]    peak_q;
  logic [N_BINS-1:0][HOLD_W-1:0] hold_q;
  logic [H_W-1:0]                peak_cur;
  logic [H_W-1:0]                peak_new;
  logic [H_W-1:0]                peak_dec;
  logic [HOLD_W-1:0]             hold_cur;
  logic [HOLD_W-1:0]             hold_new;

  always_comb begin
    peak_cur = peak_q[bin_idx_q];
    hold_cur = hold_q[bin_idx_q];
    peak_new = peak_cur;
    hold_new = hold_cur;
    peak_dec = (peak_cur > H_W'(DECAY_STEP)) ? peak_cur - H_W'(DECAY_STEP) : '0;
    if (height_new >= peak_cur) begin
      peak_new = height_new;
      hold_new = HOLD_W'(PEAK_HOLD_FRAMES);
    end else if (hold_cur != '0) begin
      hold_new = hold_cur - 1'b1;
    end else begin
      peak_new = (peak_dec > height_new) ? peak_dec : height_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_q <= '0;
      hold_q <= '0;
    end else if (state_q == UPDATE) begin
      peak_q[bin_idx_q] <= peak_new;
      hold_q[bin_idx_q] <= hold_new;
    end
  end
`else
  logic unused_peak_cfg;
  assign unused_peak_cfg = ^{32'(PEAK_HOLD_FRAMES), 32'(DECAY_STEP)};
`endif

  logic [BIN_W-1:0] bar_q;
  logic             in_bars_q;
  logic             gap_q;
  logic             row_vld_q;
  logic [10:0]      row_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bar_q     <= '0;
      in_bars_q <= 1'b0;
      gap_q     <= 1'b0;
      row_vld_q <= 1'b0;
      row_q     <= '0;
    end else begin
      bar_q     <= BIN_W'(32'(i_VGA_X) / BAR_W);
      in_bars_q <= (32'(i_VGA_X) < 32'(BARS_PX));
      gap_q     <= ((32'(i_VGA_X) % BAR_W) == 32'(BAR_W - 1));
      row_vld_q <= (32'(i_VGA_Y) < 32'(SCREEN_H));
      row_q     <= 11'(32'(SCREEN_H - 1) - 32'(i_VGA_Y));
    end
  end

  rgb_t           pix_d;
  rgb_t           pix_q;
  logic [H_W-1:0] h_sel;
`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [H_W-1:0] peak_sel;
  assign peak_sel = peak_q[bar_q];
`endif

  always_comb begin
    pix_d = C_BLACK;
    h_sel = height_q[bar_q];
    if (!row_vld_q || !in_bars_q || gap_q) begin
      pix_d = C_BLACK;
`ifdef SPECTRUM_PEAK_HOLD_EN
    end else if (peak_sel != '0 &&
                 ((12'(row_q) + 12'd1 == 12'(peak_sel)) ||
                  (12'(row_q) + 12'd2 == 12'(peak_sel)))) begin
      pix_d = C_WHITE;
`endif
    end else if (12'(row_q) < 12'(h_sel)) begin
      pix_d = C_GREEN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_q <= C_BLACK;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign o_VGA_R = pix_q.r;
  assign o_VGA_G = pix_q.g;
  assign o_VGA_B = pix_q.b;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Directed bench for spectrum_bar_renderer at default parameters; peak-hold scenarios
// run only when SPECTRUM_PEAK_HOLD_EN is defined.
module tb_spectrum_bar_renderer;

  typedef logic [31:0][15:0] frame_t;

  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  frame_t      fft_data;
  logic        fft_done;
  logic        frame_start;
  logic [10:0] vga_x;
  logic [10:0] vga_y;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  spectrum_bar_renderer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fft_data    (fft_data),
    .i_fft_done    (fft_done),
    .i_frame_start (frame_start),
    .i_VGA_X       (vga_x),
    .i_VGA_Y       (vga_y),
    .o_VGA_R       (vga_r),
    .o_VGA_G       (vga_g),
    .o_VGA_B       (vga_b),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, vga_r, vga_g, vga_b};
  endfunction

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    vga_x = 11'(x);
    vga_y = 11'(y);
    step();
    step();
    check(tag, rgb(), {8'h00, exp});
  endtask

  task automatic fft(input frame_t d);
    fft_data = d;
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_frame();
    int n;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    frame_t d;
    int     n;

    rst         = 1'b1;
    fft_data    = '0;
    fft_done    = 1'b0;
    frame_start = 1'b0;
    vga_x       = 11'd48;
    vga_y       = 11'd479;
    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rgb", rgb(), 32'(BLACK));
    rst = 1'b0;
    pix("rst_height", 48, 479, BLACK);

    // Positive bin 3: 0x0100 -> lg 8 -> height 144; other bins 0 -> height 16
    d = '0;
    d[3] = 16'h0100;
    fft(d);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("busy_len", 32'(n), 32'd32);
    pix("pos_bottom", 48, 479, GREEN);
    pix("pos_right", 62, 479, GREEN);
    pix("pos_row141", 55, 338, GREEN);
    pix("pos_row144", 55, 335, BLACK);
    pix("pos_gap", 63, 400, BLACK);
    pix("zero_row13", 0, 466, GREEN);
    pix("zero_row16", 0, 463, BLACK);

    // Negative magnitude and most-negative saturation
    d = '0;
    d[5] = 16'hFF00;
    d[6] = 16'h8000;
    fft(d);
    do_frame();
    pix("neg_row141", 80, 338, GREEN);
    pix("neg_row144", 80, 335, BLACK);
    pix("sat_row237", 96, 242, GREEN);
    pix("sat_row240", 96, 239, BLACK);
    pix("old_bin3", 48, 463, BLACK);

    // Off-screen streaming: one pixel per cycle, each result 2 cycles after its X/Y
    vga_x = 11'd48;  vga_y = 11'd479;
    step();
    vga_x = 11'd512; vga_y = 11'd479;
    step();
    check("stream_in", rgb(), 32'(GREEN));
    vga_x = 11'd80;  vga_y = 11'd400;
    step();
    check("stream_x512", rgb(), 32'(BLACK));
    vga_x = 11'd48;  vga_y = 11'd480;
    step();
    check("stream_in2", rgb(), 32'(GREEN));
    vga_x = 11'd600; vga_y = 11'd100;
    step();
    check("stream_y480", rgb(), 32'(BLACK));
    step();
    check("stream_x600", rgb(), 32'(BLACK));

    // Two captures before one frame: newest data wins
    d = '0;
    d[3] = 16'h7FFF;
    fft(d);
    d[3] = 16'h0001;
    fft(d);
    do_frame();
    pix("sync_row13", 48, 466, GREEN);
    pix("sync_row16", 48, 463, BLACK);

    // Capture coincident with frame start: old shadow is shown, new one next frame
    d = '0;
    d[3] = 16'h0010;
    fft(d);
    d[3] = 16'h0400;
    fft_data    = d;
    fft_done    = 1'b1;
    frame_start = 1'b1;
    step();
    fft_done    = 1'b0;
    frame_start = 1'b0;
    wait_idle(n);
    pix("simul_old77", 48, 402, GREEN);
    pix("simul_old80", 48, 399, BLACK);
    do_frame();
    pix("simul_new173", 48, 306, GREEN);
    pix("simul_new176", 48, 303, BLACK);

    // Reset during UPDATE cycle 10
    vga_x = 11'd48;
    vga_y = 11'd479;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (10) step();
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy_after", {31'd0, busy}, 32'd0);
    check("mid_rgb_after", rgb(), 32'(BLACK));
    step();
    step();
    check("mid_rgb_2cyc", rgb(), 32'(BLACK));
    pix("mid_bin0", 0, 479, BLACK);
    do_frame();
    pix("mid_work_clear13", 48, 466, GREEN);
    pix("mid_work_clear16", 48, 463, BLACK);

`ifdef SPECTRUM_PEAK_HOLD_EN
    d = '0;
    d[0] = 16'h0100;
    fft(d);
    do_frame();
    pix("pk_row143", 0, 336, WHITE);
    pix("pk_row142", 0, 337, WHITE);
    pix("pk_row141", 0, 338, GREEN);
    pix("pk_row144", 0, 335, BLACK);
    fft('0);
    for (int f = 1; f <= 30; f++) begin
      do_frame();
      pix("pk_hold", 0, 336, WHITE);
    end
    pix("pk_hold_bar", 0, 466, GREEN);
    do_frame();
    pix("pk_dec139", 0, 340, WHITE);
    pix("pk_dec138", 0, 341, WHITE);
    pix("pk_dec140", 0, 339, BLACK);
    pix("pk_dec_old", 0, 336, BLACK);
    for (int f = 0; f < 40; f++) do_frame();
    pix("pk_floor15", 0, 464, WHITE);
    pix("pk_floor14", 0, 465, WHITE);
    pix("pk_floor13", 0, 466, GREEN);
    pix("pk_floor16", 0, 463, BLACK);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
